// File: rtl/ula_wb_stage.sv
// ALU-to-writeback stage: 2-entry in-order skid buffer carrying result and destination,
// plus the architectural flag register and conditional-branch resolution at accept time.
module ula_wb_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_o,
   input  logic              in_c,
   input  logic              in_s,
   input  logic              in_z,
   input  logic              in_flag_we,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_rd_we,
   input  logic              in_is_branch,
   input  logic [3:0]        in_cond,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_rd_we,
   output logic              out_branch_taken,
   output logic [3:0]        flags_q
);

   logic [DATA_W-1:0] r_result [2];
   logic [RD_W-1:0]   r_rd     [2];
   logic [1:0]        r_rd_we;
   logic [1:0]        r_taken;
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic [3:0]        r_flags;

   logic              w_accept;
   logic              w_pop;
   logic              w_taken;

   // Flags are packed {O,C,S,Z}; codes 12..15 are never taken.
   function automatic logic f_cond_true(input logic [3:0] cond, input logic [3:0] flg);
      logic o, c, s, z;
      o = flg[3];
      c = flg[2];
      s = flg[1];
      z = flg[0];
      case (cond)
         4'd0:    f_cond_true = 1'b1;
         4'd1:    f_cond_true = z;
         4'd2:    f_cond_true = ~z;
         4'd3:    f_cond_true = s;
         4'd4:    f_cond_true = ~s;
         4'd5:    f_cond_true = c;
         4'd6:    f_cond_true = ~c;
         4'd7:    f_cond_true = o;
         4'd8:    f_cond_true = ~o;
         4'd9:    f_cond_true = s ^ o;
         4'd10:   f_cond_true = ~(s ^ o) & ~z;
         4'd11:   f_cond_true = c | z;
         default: f_cond_true = 1'b0;
      endcase
   endfunction

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_accept  = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   // Branches see the flags as they stood before this edge.
   assign w_taken   = in_is_branch & f_cond_true(in_cond, r_flags);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result[0] <= '0;
         r_result[1] <= '0;
         r_rd[0]     <= '0;
         r_rd[1]     <= '0;
         r_rd_we     <= '0;
         r_taken     <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_flags     <= 4'd0;
      end else begin
         if (w_accept) begin
            r_result[r_wr_ptr] <= in_result;
            r_rd[r_wr_ptr]     <= in_rd;
            r_rd_we[r_wr_ptr]  <= in_rd_we & ~in_is_branch;
            r_taken[r_wr_ptr]  <= w_taken;
            r_wr_ptr           <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (w_accept && in_flag_we && !in_is_branch) begin
            r_flags <= {in_o, in_c, in_s, in_z};
         end
      end
   end

   // Outputs come from head registers only, never from in_*.
   assign out_result       = r_result[r_rd_ptr];
   assign out_rd           = r_rd[r_rd_ptr];
   assign out_rd_we        = r_rd_we[r_rd_ptr];
   assign out_branch_taken = r_taken[r_rd_ptr];
   assign flags_q          = r_flags;

endmodule

// File: tb/tb_ula_wb_stage.sv
// Randomized and directed bench for ula_wb_stage against a queue-based reference model.
module tb_ula_wb_stage;

   localparam int DATA_W = 32;
   localparam int RD_W   = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_o, in_c, in_s, in_z;
   logic              in_flag_we;
   logic [RD_W-1:0]   in_rd;
   logic              in_rd_we;
   logic              in_is_branch;
   logic [3:0]        in_cond;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [RD_W-1:0]   out_rd;
   logic              out_rd_we;
   logic              out_branch_taken;
   logic [3:0]        flags_q;

   ula_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_o(in_o), .in_c(in_c), .in_s(in_s), .in_z(in_z),
      .in_flag_we(in_flag_we), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .in_is_branch(in_is_branch), .in_cond(in_cond),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_branch_taken(out_branch_taken),
      .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] res;
      logic [RD_W-1:0]   rd;
      logic              we;
      logic              tk;
   } ent_t;

   ent_t        m_q[$];
   logic [3:0]  m_flags;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference condition evaluation written from the arithmetic meaning of each code.
   function automatic logic m_taken(input logic [3:0] cond, input logic [3:0] f);
      bit o, c, s, z;
      {o, c, s, z} = f;
      if (cond == 4'd0)  return 1'b1;
      if (cond == 4'd1)  return z;
      if (cond == 4'd2)  return !z;
      if (cond == 4'd3)  return s;
      if (cond == 4'd4)  return !s;
      if (cond == 4'd5)  return c;
      if (cond == 4'd6)  return !c;
      if (cond == 4'd7)  return o;
      if (cond == 4'd8)  return !o;
      if (cond == 4'd9)  return s != o;
      if (cond == 4'd10) return (s == o) && !z;
      if (cond == 4'd11) return c || z;
      return 1'b0;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_q.size() < 2));
      chk({tag, ".flags_q"}, 64'(flags_q), 64'(m_flags));
      if (m_q.size() != 0) begin
         chk({tag, ".result"}, 64'(out_result), 64'(m_q[0].res));
         chk({tag, ".rd"}, 64'(out_rd), 64'(m_q[0].rd));
         chk({tag, ".rd_we"}, 64'(out_rd_we), 64'(m_q[0].we));
         chk({tag, ".taken"}, 64'(out_branch_taken), 64'(m_q[0].tk));
      end
   endtask

   // Inputs are already driven; advance one edge, update the model, check.
   task automatic step(input string tag);
      bit   acc, pop;
      ent_t e;
      acc = in_valid && (m_q.size() < 2);
      pop = (m_q.size() != 0) && out_ready;
      e.res = in_result;
      e.rd  = in_rd;
      e.we  = in_is_branch ? 1'b0 : in_rd_we;
      e.tk  = in_is_branch ? m_taken(in_cond, m_flags) : 1'b0;
      @(posedge clk);
      if (pop) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back(e);
         if (in_flag_we && !in_is_branch) m_flags = {in_o, in_c, in_s, in_z};
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] res, input logic [RD_W-1:0] rd,
                        input logic rdwe, input logic fwe, input logic [3:0] ocsz,
                        input logic br, input logic [3:0] cond, input logic ordy);
      in_valid = v; in_result = res; in_rd = rd; in_rd_we = rdwe;
      in_flag_we = fwe; {in_o, in_c, in_s, in_z} = ocsz;
      in_is_branch = br; in_cond = cond; out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      m_flags = 4'd0;
      drive(0, '0, '0, 0, 0, 4'd0, 0, 4'd0, 0);
      #2;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.flags", 64'(flags_q), 64'd0);
      chk("rst.result", 64'(out_result), 64'd0);
      chk("rst.rd", 64'(out_rd), 64'd0);
      chk("rst.rd_we", 64'(out_rd_we), 64'd0);
      chk("rst.taken", 64'(out_branch_taken), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single entry, one-cycle latency, then drained
      drive(1, 32'h5, 5'd3, 1, 0, 4'd0, 0, 4'd0, 1);
      step("t1.acc");
      chk("t1.lat_result", 64'(out_result), 64'h5);
      drive(0, '0, '0, 0, 0, 4'd0, 0, 4'd0, 1);
      step("t1.pop");
      chk("t1.empty", 64'(out_valid), 64'd0);

      // 2: backpressure, third entry held by the source
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'hA + 32'(m_q.size()), 5'd1 + 5'(m_q.size()), 1, 0, 4'd0, 0, 4'd0, 0);
         step("t2.fill");
      end
      chk("t2.full", 64'(in_ready), 64'd0);
      for (int i = 0; i < 4 && (m_q.size() != 0 || in_valid); i++) begin
         chk("t2.order", 64'(out_result), 64'(32'hA + 32'(i)));
         if (in_valid && m_q.size() < 2) begin
            drive(1, 32'hC, 5'd3, 1, 0, 4'd0, 0, 4'd0, 1);
            step("t2.drain");
            drive(0, '0, '0, 0, 0, 4'd0, 0, 4'd0, 1);
         end else begin
            out_ready = 1;
            step("t2.drain");
         end
      end
      chk("t2.done", 64'(out_valid), 64'd0);

      // 3: streaming at count=1 with simultaneous accept and pop
      drive(1, 32'd1, 5'd7, 1, 0, 4'd0, 0, 4'd0, 1);
      step("t3.prime");
      for (int v = 2; v <= 10; v++) begin
         drive(1, 32'(v), 5'd7, 1, 0, 4'd0, 0, 4'd0, 1);
         step("t3.stream");
         chk("t3.value", 64'(out_result), 64'(v));
      end
      drive(0, '0, '0, 0, 0, 4'd0, 0, 4'd0, 1);
      step("t3.drain");

      // 4: Z=1 flag writer, then branches on Z / !Z
      drive(1, 32'h0, 5'd2, 1, 1, 4'b0001, 0, 4'd0, 1);
      step("t4.fw");
      chk("t4.flags", 64'(flags_q), 64'b0001);
      drive(1, 32'h40, 5'd9, 1, 1, 4'b1110, 1, 4'b0001, 1);
      step("t4.brZ");
      chk("t4.takenZ", 64'(out_branch_taken), 64'd1);
      chk("t4.rdwe", 64'(out_rd_we), 64'd0);
      chk("t4.flags_hold", 64'(flags_q), 64'b0001);
      drive(1, 32'h44, 5'd9, 1, 0, 4'd0, 1, 4'b0010, 1);
      step("t4.brNZ");
      chk("t4.takenNZ", 64'(out_branch_taken), 64'd0);

      // 5: O=1,S=0 -> signed-less taken; code 15 never; branch flag_we ignored
      drive(1, 32'h1, 5'd4, 1, 1, 4'b1000, 0, 4'd0, 1);
      step("t5.fw");
      drive(1, 32'h50, 5'd0, 0, 0, 4'd0, 1, 4'b1001, 1);
      step("t5.lt");
      chk("t5.taken_lt", 64'(out_branch_taken), 64'd1);
      drive(1, 32'h54, 5'd0, 0, 1, 4'b0111, 1, 4'b1111, 1);
      step("t5.never");
      chk("t5.taken_never", 64'(out_branch_taken), 64'd0);
      chk("t5.flags_hold", 64'(flags_q), 64'b1000);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 1'($urandom),
               1'($urandom), 4'($urandom), 1'($urandom_range(0, 9) < 3),
               4'($urandom), 1'($urandom_range(0, 9) < 6));
         step("rnd");
      end

      // 6: asynchronous reset with two entries buffered and flags 1010
      drive(1, 32'h77, 5'd5, 1, 1, 4'b1010, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) step("t6.fill");
      chk("t6.flags", 64'(flags_q), 64'b1010);
      #2;
      rst_n = 1'b0;
      #1;
      m_q.delete();
      m_flags = 4'd0;
      chk("t6.rst_valid", 64'(out_valid), 64'd0);
      chk("t6.rst_ready", 64'(in_ready), 64'd1);
      chk("t6.rst_flags", 64'(flags_q), 64'd0);
      drive(0, '0, '0, 0, 0, 4'd0, 0, 4'd0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) step("t6.post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
